// File: rtl/systolic_skew_scheduler_pkg.sv
// Shared types and constants for the systolic array edge scheduler.
package systolic_pkg;

    localparam int N_DEF       = 4;
    localparam int DATA_W_DEF  = 32;
    localparam int MAX_LEN_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    // N-1 cycles of skew, 2N-2 of propagation and 1 for the final PE accumulation.
    function automatic int drain_cycles(input int n);
        return 3 * n - 2;
    endfunction

endpackage

// File: rtl/systolic_skew_scheduler_delay.sv
// Fixed-depth register delay line. It feeds one array edge lane with its diagonal skew.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int s = 1; s < DEPTH; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_scheduler.sv
// Skewed west/north edge driver for an NxN output-stationary systolic array.
// Optional SKEW_SCHED_STALL_CNT_EN adds a saturating stall_cnt output.
module systolic_skew_scheduler
    import systolic_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(MAX_LEN+1)-1:0]   len,
    input  logic [N*DATA_W-1:0]            a_vec,
    input  logic [N*DATA_W-1:0]            b_vec,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [N*DATA_W-1:0]            west_o,
    output logic [N*DATA_W-1:0]            north_o,
    output logic                           acc_clr,
    output logic                           busy,
    output logic                           done
`ifdef SKEW_SCHED_STALL_CNT_EN
    ,output logic [15:0]                   stall_cnt
`endif
);

    localparam int LEN_W     = $clog2(MAX_LEN + 1);
    localparam int DRAIN_CYC = drain_cycles(N);
    localparam int DCNT_W    = $clog2(3 * N - 1);

    state_e              state_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    beat_q;
    logic [DCNT_W-1:0]   drain_q;
    logic                in_ready_q;
    logic                busy_q;
    logic                acc_clr_q;
    logic                done_q;

    logic                len_ok;
    logic                start_acc;
    logic                beat_acc;

    logic [N-1:0][DATA_W-1:0] a_lanes, b_lanes;
    logic [N-1:0][DATA_W-1:0] west_lanes, north_lanes;

    assign len_ok    = (len != '0) && (len <= LEN_W'(MAX_LEN));
    assign start_acc = (state_q == IDLE) && start && len_ok;
    assign beat_acc  = in_valid && in_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            beat_q     <= '0;
            drain_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            acc_clr_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_acc) begin
                        state_q    <= STREAM;
                        len_q      <= len;
                        beat_q     <= '0;
                        acc_clr_q  <= 1'b1;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                STREAM: begin
                    if (beat_acc) begin
                        if (beat_q == len_q - LEN_W'(1)) begin
                            state_q    <= DRAIN;
                            drain_q    <= '0;
                            in_ready_q <= 1'b0;
                        end else begin
                            beat_q <= beat_q + LEN_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == DCNT_W'(DRAIN_CYC - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + DCNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign a_lanes = a_vec;
    assign b_lanes = b_vec;

    // Non-beat cycles push zeros so the skew stays aligned across bubbles.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(.DEPTH(i + 1), .WIDTH(DATA_W)) u_west (
            .clk (clk),
            .rst (rst),
            .d_i (beat_acc ? a_lanes[i] : '0),
            .q_o (west_lanes[i])
        );
        skew_delay_line #(.DEPTH(i + 1), .WIDTH(DATA_W)) u_north (
            .clk (clk),
            .rst (rst),
            .d_i (beat_acc ? b_lanes[i] : '0),
            .q_o (north_lanes[i])
        );
    end

    assign west_o   = west_lanes;
    assign north_o  = north_lanes;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign acc_clr  = acc_clr_q;
    assign done     = done_q;

`ifdef SKEW_SCHED_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (state_q == STREAM && !in_valid && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_systolic_skew_scheduler.sv
// Directed bench for systolic_skew_scheduler (N=4, DATA_W=32, MAX_LEN=8).
module tb_systolic_skew_scheduler;

    localparam int N       = 4;
    localparam int DATA_W  = 32;
    localparam int MAX_LEN = 8;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [LW-1:0]       len;
    logic [N*DATA_W-1:0] a_vec, b_vec;
    logic                in_valid;
    logic                in_ready;
    logic [N*DATA_W-1:0] west_o, north_o;
    logic                acc_clr, busy, done;
`ifdef SKEW_SCHED_STALL_CNT_EN
    logic [15:0]         stall_cnt;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    systolic_skew_scheduler #(.N(N), .DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .a_vec    (a_vec),
        .b_vec    (b_vec),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .west_o   (west_o),
        .north_o  (north_o),
        .acc_clr  (acc_clr),
        .busy     (busy),
        .done     (done)
`ifdef SKEW_SCHED_STALL_CNT_EN
        ,.stall_cnt(stall_cnt)
`endif
    );

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            start    = 1'($urandom);
            len      = LW'($urandom);
            in_valid = 1'($urandom);
            a_vec    = {4{$urandom}};
            b_vec    = {4{$urandom}};
            @(posedge clk); #1;
        end
        vectors++; if (west_o !== '0) begin miscompares++; $display("FAIL reset_west: got %h want 0", west_o); end
        vectors++; if (north_o !== '0) begin miscompares++; $display("FAIL reset_north: got %h want 0", north_o); end
        vectors++; if ({in_ready, acc_clr, busy, done} !== 4'b0) begin
            miscompares++; $display("FAIL reset_ctl: rdy/clr/busy/done=%b want 0000", {in_ready, acc_clr, busy, done});
        end
        rst   = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'($urandom);
            a_vec    = {4{$urandom}};
            b_vec    = {4{$urandom}};
            @(posedge clk); #1;
            vectors++; if (west_o !== '0 || north_o !== '0) begin
                miscompares++; $display("FAIL idle_data c%0d: west %h north %h want 0", c, west_o, north_o);
            end
            vectors++; if ({in_ready, acc_clr, busy, done} !== 4'b0) begin
                miscompares++; $display("FAIL idle_ctl c%0d: got %b want 0000", c, {in_ready, acc_clr, busy, done});
            end
        end
        in_valid = 1'b0;
    endtask

    // vmask bit r: a beat is offered in the cycle before edge r (edge 0 is the start edge).
    task automatic run_job(input string name, input int L, input logic [31:0] vmask,
                           input int done_rel, input bit hold_start, input bit junk,
                           input int abort_rel);
        int acc_edge[MAX_LEN];
        int nb;
        int el;
        logic [N-1:0][DATA_W-1:0] da, db, ew, en;
        nb = 0;
        for (int k = 0; k < MAX_LEN; k++) acc_edge[k] = -100;
        for (int r = 1; r < 32; r++) begin
            if (vmask[r] && nb < MAX_LEN) begin
                acc_edge[nb] = r;
                nb++;
            end
        end
        el = acc_edge[L-1];

        start = 1'b1; len = LW'(L); in_valid = 1'b0; a_vec = '0; b_vec = '0;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        vectors++; if (acc_clr !== 1'b1) begin miscompares++; $display("FAIL %s acc_clr r0: got %b want 1", name, acc_clr); end
        vectors++; if (in_ready !== 1'b1 || busy !== 1'b1) begin
            miscompares++; $display("FAIL %s rdy/busy r0: got %b%b want 11", name, in_ready, busy);
        end

        for (int r = 1; r <= done_rel + 1; r++) begin
            for (int i = 0; i < N; i++) begin
                da[i] = DATA_W'(32'hBAD0_0000 + i);
                db[i] = DATA_W'(32'hBEE0_0000 + i);
            end
            in_valid = junk && (r > el);
            for (int k = 0; k < L; k++) begin
                if (acc_edge[k] == r) begin
                    in_valid = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        da[i] = DATA_W'(10 * i + k + 1);
                        db[i] = DATA_W'(10 * i + k + 501);
                    end
                end
            end
            a_vec = da;
            b_vec = db;
            if (r == abort_rel) rst = 1'b1;
            @(posedge clk); #1;

            if (r == abort_rel) begin
                rst = 1'b0; in_valid = 1'b0; start = 1'b0;
                vectors++; if (west_o !== '0 || north_o !== '0) begin
                    miscompares++; $display("FAIL %s abort_data: west %h north %h want 0", name, west_o, north_o);
                end
                vectors++; if ({in_ready, acc_clr, busy, done} !== 4'b0) begin
                    miscompares++; $display("FAIL %s abort_ctl: got %b want 0000", name, {in_ready, acc_clr, busy, done});
                end
                return;
            end

            ew = '0; en = '0;
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < L; k++) begin
                    if (acc_edge[k] + i == r) begin
                        ew[i] = DATA_W'(10 * i + k + 1);
                        en[i] = DATA_W'(10 * i + k + 501);
                    end
                end
            end
            vectors++; if (west_o !== ew) begin miscompares++; $display("FAIL %s west r%0d: got %h want %h", name, r, west_o, ew); end
            vectors++; if (north_o !== en) begin miscompares++; $display("FAIL %s north r%0d: got %h want %h", name, r, north_o, en); end
            vectors++; if (in_ready !== (r < el)) begin miscompares++; $display("FAIL %s in_ready r%0d: got %b want %b", name, r, in_ready, r < el); end
            vectors++; if (busy !== (r <= done_rel)) begin miscompares++; $display("FAIL %s busy r%0d: got %b want %b", name, r, busy, r <= done_rel); end
            vectors++; if (acc_clr !== 1'b0) begin miscompares++; $display("FAIL %s acc_clr r%0d: got %b want 0", name, r, acc_clr); end
            vectors++; if (done !== (r == done_rel)) begin miscompares++; $display("FAIL %s done r%0d: got %b want %b", name, r, done, r == done_rel); end
        end
        start = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0 || acc_clr !== 1'b0) begin
            miscompares++; $display("FAIL %s post_idle: busy %b acc_clr %b want 00", name, busy, acc_clr);
        end
    endtask

    task automatic test_basic();
        run_job("basic", 4, 32'h0000_001E, 14, 1'b0, 1'b0, 0);
    endtask

    task automatic test_bubble();
        run_job("bubble", 4, 32'h0000_0066, 16, 1'b0, 1'b0, 0);
`ifdef SKEW_SCHED_STALL_CNT_EN
        vectors++; if (stall_cnt !== 16'd2) begin miscompares++; $display("FAIL bubble stall_cnt: got %0d want 2", stall_cnt); end
`endif
    endtask

    task automatic test_bad_len();
        logic [LW-1:0] bad [3];
        bad[0] = LW'(0); bad[1] = LW'(9); bad[2] = LW'(15);
        for (int t = 0; t < 3; t++) begin
            start = 1'b1; len = bad[t]; in_valid = 1'b1;
            a_vec = {4{32'h1234_5678}}; b_vec = {4{32'h8765_4321}};
            for (int c = 0; c < 2; c++) begin
                @(posedge clk); #1;
                vectors++; if ({in_ready, acc_clr, busy, done} !== 4'b0) begin
                    miscompares++; $display("FAIL bad_len %0d: rdy/clr/busy/done=%b want 0000", bad[t], {in_ready, acc_clr, busy, done});
                end
                vectors++; if (west_o !== '0 || north_o !== '0) begin
                    miscompares++; $display("FAIL bad_len %0d data: west %h north %h want 0", bad[t], west_o, north_o);
                end
            end
        end
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset_drain();
        run_job("abort", 4, 32'h0000_001E, 14, 1'b0, 1'b0, 7);
        run_job("after_abort", 2, 32'h0000_0006, 12, 1'b0, 1'b0, 0);
    endtask

    task automatic test_start_ignored();
        run_job("start_held", 3, 32'h0000_0046, 16, 1'b1, 1'b1, 0);
`ifdef SKEW_SCHED_STALL_CNT_EN
        vectors++; if (stall_cnt !== 16'd3) begin miscompares++; $display("FAIL start_held stall_cnt: got %0d want 3", stall_cnt); end
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; a_vec = '0; b_vec = '0;
        test_reset();
        test_basic();
        test_bubble();
        test_bad_len();
        test_reset_drain();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
